icache_ctrl: RTL
================

# icache_ctrl

Lookup and refill controller for the 2-way, 64-set, 16-byte-line instruction cache. It accepts word fetches from the core, drives the `cache_mem_wrap` tag/data array to check for a hit, and on a miss refills the line from the instruction memory bus with four single-word reads. It also runs a full-cache invalidate on request. It sits between the core instruction port and `cache_mem_wrap`; a thin `icache` top instantiates both.

## Interface
- `SET_W`, 6, set index width (64 sets).
- `TAG_W`, 22, tag width: address bits [31:10].
- `LINE_WORDS`, 4, 32-bit words per line; word select is address bits [3:2].
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  fetch address; bits [1:0] are ignored.
- `instr_gnt_o`  out  1  request accepted.
- `instr_rvalid_o`  out  1  one-cycle strobe; `instr_rdata_o` is valid.
- `instr_rdata_o`  out  32  fetched word.
- `flush_i`  in  1  invalidate-all pulse.
- `flush_busy_o`  out  1  high while the invalidate is running.
- `mem_req_o`, `mem_addr_o[31:0]`  out  refill read request and word address.
- `mem_gnt_i`, `mem_rvalid_i`  in  1  refill handshake.
- `mem_rdata_i`  in  32  refill data.
- `cm_set_o[5:0]`, `cm_way_o[0:0]`, `cm_enable_o`, `cm_write_enable_o`, `cm_val_write_enable_o`, `cm_line_valid_o`, `cm_line_tag_o[21:0]`, `cm_line_o[127:0]`, `cm_line_ww_enable_o[3:0]`  out  cache array control and write data.
- `cm_line_valid_i[1:0]`, `cm_line_tag_i[43:0]` (way w at [22w+:22]), `cm_line_i[127:0]`  in  array read data.

## Operation
- States: IDLE, TAG, DATA, REFILL_REQ, REFILL_WAIT, FILL, FLUSH.
- Array contract:
  - Reads are synchronous, one cycle. Tags and valid bits for both ways come back the cycle after `cm_enable_o` with `cm_write_enable_o` low.
  - `cm_line_i` returns the way given by `cm_way_o` in the issue cycle.
  - `cm_write_enable_o` together with `cm_val_write_enable_o` writes tag, the enabled words and the valid bit.
  - `cm_val_write_enable_o` alone writes only the valid bit.
- IDLE:
  - A pending flush has priority over a request: go to FLUSH.
  - Otherwise, if `instr_req_i` is high: `instr_gnt_o`=1 combinationally, latch the address, issue a tag read of set addr[9:4], go to TAG.
  - `instr_gnt_o` is 0 in every other state.
- TAG: way w hits when `cm_line_valid_i[w]` is set and its tag equals addr[31:10].
  - Hit: read data with `cm_way_o`=hit way, go to DATA.
  - Miss: choose the victim and go to REFILL_REQ with word counter = 0.
  - Victim choice: way 0 if invalid, else way 1 if invalid, else ~`lru[set]`.
- DATA: `instr_rvalid_o`=1, `instr_rdata_o`=`cm_line_i[32*addr[3:2]+:32]`, `lru[set]`←hit way, go to IDLE.
- REFILL_REQ: `mem_req_o`=1, `mem_addr_o`={tag, set, cnt, 2'b00}. Hold until `mem_gnt_i`, then go to REFILL_WAIT.
- REFILL_WAIT: on `mem_rvalid_i`, `buf[cnt]`←`mem_rdata_i`. If cnt==3 go to FILL, else cnt+1 and go to REFILL_REQ. `mem_rvalid_i` never arrives in the same cycle as its grant.
- FILL:
  - Write the array at (set, victim): enable, write_enable, val_write_enable, valid=1, tag, line=buf, `cm_line_ww_enable_o`=4'hF.
  - Same cycle: `instr_rvalid_o`=1 with `buf[addr[3:2]]`, `lru[set]`←victim, go to IDLE.
- FLUSH:
  - Clear `lru`.
  - Walk a 7-bit counter {set, way} from 0 to 127, one valid-only write per cycle with `cm_line_valid_o`=0.
  - Go to IDLE after 127.
- Flush latch: `flush_i` seen in any state other than IDLE/FLUSH sets a pending flag, serviced at the next IDLE. `flush_i` during FLUSH is ignored.
- `lru` is a 64-bit register, reset 0.

## Timing
- Hit: `instr_rvalid_o` arrives 2 cycles after the grant. At most one request is accepted every 3 cycles.
- Miss with zero-wait memory (grant same cycle, rvalid next cycle): `instr_rvalid_o` at grant+10.
- Flush: `flush_busy_o` stays high for exactly 128 cycles.
- Reset, including mid-refill or mid-flush:
  - State goes to IDLE; counters, `buf`, `lru` and the pending flag go to 0.
  - All outputs go to 0.
  - The refill in flight is dropped; no array write follows.
  - Array contents are not cleared by this block.

## Structure
- `icache_pkg`: `SET_W`, `TAG_W`, `LINE_WORDS`, `WAYS`=2, the state enum, and address-field slice helpers.
- One sub-module, `icache_refill`, holds the REFILL_REQ/REFILL_WAIT engine: word counter, 128-bit buffer, and a done pulse.

## Test plan
- Cold miss at 0x0000_1234 with memory returning 0x11,0x22,0x33,0x44:
  - Memory reads at 0x1230, 0x1234, 0x1238, 0x123C.
  - FILL writes set 0x23, way 0, tag 0x000004.
  - `instr_rdata_o`=0x22 at grant+10.
- Refetch of 0x0000_1238 → hit, rdata 0x33 at grant+2, no memory request.
- Fill way 1 of set 0x23 with a second tag, touch way 1, then miss a third tag → victim is way 0.
- Pulse `flush_i` during REFILL_WAIT:
  - The refill completes and rvalid fires.
  - FLUSH then runs for 128 cycles.
  - Refetching 0x1234 misses.
- Hold `mem_gnt_i` low for 5 cycles → `mem_req_o` and `mem_addr_o` stay stable, and rvalid is delayed by 5 cycles.
- Drop `rst_n` during the third refill word:
  - All outputs go to 0 asynchronously, with no array write.
  - The next request is granted in IDLE.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the instruction cache.
package icache_pkg;

    localparam int unsigned SET_W      = 6;
    localparam int unsigned TAG_W      = 22;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned LINE_W     = 32 * LINE_WORDS;
    localparam int unsigned CNT_W      = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StTag,
        StData,
        StRefillReq,
        StRefillWait,
        StFill,
        StFlush
    } state_e;

    function automatic logic [SET_W-1:0] addr_set(input logic [31:0] addr);
        return addr[4 +: SET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic logic [CNT_W-1:0] addr_word(input logic [31:0] addr);
        return addr[2 +: CNT_W];
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Refill engine: word counter, line buffer and memory request/address generation.
module icache_refill
    import icache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     req_phase_i,
    input  logic                     wait_phase_i,
    input  logic [TAG_W+SET_W-1:0]   line_addr_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    output logic [LINE_W-1:0]        buf_o,
    output logic                     next_o,
    output logic                     done_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic              last_word;

    assign last_word  = (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign mem_req_o  = req_phase_i;
    assign mem_addr_o = req_phase_i ? {line_addr_i, cnt_q, 2'b00} : '0;
    assign buf_o      = buf_q;
    assign done_o     = wait_phase_i & mem_rvalid_i & last_word;
    assign next_o     = wait_phase_i & mem_rvalid_i & ~last_word;

    // Capture returning words into the buffer and advance the word counter.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_phase_i && mem_rvalid_i) begin
            buf_d[32*cnt_q +: 32] = mem_rdata_i;
            cnt_d                 = cnt_q + 1'b1;
        end
    end

    // Counter and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Lookup, refill and invalidate controller for the 2-way instruction cache.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [31:0]             instr_rdata_o,
    input  logic                    flush_i,
    output logic                    flush_busy_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i,
    output logic [SET_W-1:0]        cm_set_o,
    output logic [0:0]              cm_way_o,
    output logic                    cm_enable_o,
    output logic                    cm_write_enable_o,
    output logic                    cm_val_write_enable_o,
    output logic                    cm_line_valid_o,
    output logic [TAG_W-1:0]        cm_line_tag_o,
    output logic [LINE_W-1:0]       cm_line_o,
    output logic [LINE_WORDS-1:0]   cm_line_ww_enable_o,
    input  logic [WAYS-1:0]         cm_line_valid_i,
    input  logic [WAYS*TAG_W-1:0]   cm_line_tag_i,
    input  logic [LINE_W-1:0]       cm_line_i
);

    state_e            state_q, state_d;
    logic [29:0]       addr_q, addr_d;
    logic              way_q, way_d;
    logic [63:0]       lru_q, lru_d;
    logic              flush_pend_q, flush_pend_d;
    logic [SET_W:0]    flush_cnt_q, flush_cnt_d;

    logic [31:0]       fetch_addr;
    logic [SET_W-1:0]  fetch_set;
    logic [TAG_W-1:0]  fetch_tag;
    logic [CNT_W-1:0]  fetch_word;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_way, victim;
    logic              refill_clear, refill_next, refill_done;
    logic [LINE_W-1:0] refill_buf;

    assign fetch_addr = {addr_q, 2'b00};
    assign fetch_set  = addr_set(fetch_addr);
    assign fetch_tag  = addr_tag(fetch_addr);
    assign fetch_word = addr_word(fetch_addr);

    // Per-way hit detection against the tags read in the previous cycle.
    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = cm_line_valid_i[w] && (cm_line_tag_i[TAG_W*w +: TAG_W] == fetch_tag);
        end
    end

    assign hit_way = ~hit_vec[0];
    // Fill an empty way first, otherwise evict the least recently used one.
    assign victim  = !cm_line_valid_i[0] ? 1'b0 :
                     !cm_line_valid_i[1] ? 1'b1 : ~lru_q[fetch_set];

    icache_refill u_refill (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (refill_clear),
        .req_phase_i  (state_q == StRefillReq),
        .wait_phase_i (state_q == StRefillWait),
        .line_addr_i  (fetch_addr[31:4]),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .buf_o        (refill_buf),
        .next_o       (refill_next),
        .done_o       (refill_done)
    );

    // Next-state logic and all array/core outputs.
    always_comb begin
        state_d               = state_q;
        addr_d                = addr_q;
        way_d                 = way_q;
        lru_d                 = lru_q;
        flush_pend_d          = flush_pend_q;
        flush_cnt_d           = flush_cnt_q;
        refill_clear          = 1'b0;
        instr_gnt_o           = 1'b0;
        instr_rvalid_o        = 1'b0;
        instr_rdata_o         = '0;
        flush_busy_o          = 1'b0;
        cm_set_o              = '0;
        cm_way_o              = '0;
        cm_enable_o           = 1'b0;
        cm_write_enable_o     = 1'b0;
        cm_val_write_enable_o = 1'b0;
        cm_line_valid_o       = 1'b0;
        cm_line_tag_o         = '0;
        cm_line_o             = '0;
        cm_line_ww_enable_o   = '0;

        // A flush arriving mid-operation waits for the next idle cycle.
        if (flush_i && (state_q != StIdle) && (state_q != StFlush)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (flush_i || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    state_d      = StFlush;
                end else if (instr_req_i) begin
                    instr_gnt_o = 1'b1;
                    addr_d      = instr_addr_i[31:2];
                    cm_enable_o = 1'b1;
                    cm_set_o    = addr_set(instr_addr_i);
                    state_d     = StTag;
                end
            end
            StTag: begin
                if (|hit_vec) begin
                    cm_enable_o = 1'b1;
                    cm_set_o    = fetch_set;
                    cm_way_o    = hit_way;
                    way_d       = hit_way;
                    state_d     = StData;
                end else begin
                    way_d        = victim;
                    refill_clear = 1'b1;
                    state_d      = StRefillReq;
                end
            end
            StData: begin
                instr_rvalid_o   = 1'b1;
                instr_rdata_o    = cm_line_i[32*fetch_word +: 32];
                lru_d[fetch_set] = way_q;
                state_d          = StIdle;
            end
            StRefillReq: begin
                if (mem_gnt_i) state_d = StRefillWait;
            end
            StRefillWait: begin
                if (refill_done) state_d = StFill;
                else if (refill_next) state_d = StRefillReq;
            end
            StFill: begin
                cm_enable_o           = 1'b1;
                cm_write_enable_o     = 1'b1;
                cm_val_write_enable_o = 1'b1;
                cm_line_valid_o       = 1'b1;
                cm_set_o              = fetch_set;
                cm_way_o              = way_q;
                cm_line_tag_o         = fetch_tag;
                cm_line_o             = refill_buf;
                cm_line_ww_enable_o   = '1;
                instr_rvalid_o        = 1'b1;
                instr_rdata_o         = refill_buf[32*fetch_word +: 32];
                lru_d[fetch_set]      = way_q;
                state_d               = StIdle;
            end
            StFlush: begin
                lru_d                 = '0;
                flush_busy_o          = 1'b1;
                cm_enable_o           = 1'b1;
                cm_val_write_enable_o = 1'b1;
                cm_set_o              = flush_cnt_q[SET_W:1];
                cm_way_o              = flush_cnt_q[0];
                flush_cnt_d           = flush_cnt_q + 1'b1;
                if (&flush_cnt_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            way_q        <= 1'b0;
            lru_q        <= '0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            way_q        <= way_d;
            lru_q        <= lru_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule
